// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, phase encoding and helper for the Pong raster controller.
package vga_timing_pkg;

    localparam int unsigned DEF_CLK_DIV  = 4;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam bit          DEF_SYNC_POL = 1'b0;

    localparam int unsigned MAX_TOTAL = 1024;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } phase_t;

    function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return axis_total(active, fp, sync, bp);
    endfunction

    function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return axis_total(active, fp, sync, bp);
    endfunction

endpackage

// File: rtl/vga_axis_fsm.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM, stepped by advance.
module vga_axis_fsm #(
    parameter int unsigned ACTIVE = 640,
    parameter int unsigned FP     = 16,
    parameter int unsigned SYNC   = 96,
    parameter int unsigned BP     = 48
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    advance,
    output logic [9:0]              count,
    output logic                    wrap,
    output vga_timing_pkg::phase_t  state_next
);

    localparam int unsigned TOTAL   = vga_timing_pkg::axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [9:0]  LAST    = 10'(TOTAL - 1);
    localparam logic [9:0]  AT_FRONT = 10'(ACTIVE);
    localparam logic [9:0]  AT_SYNC  = 10'(ACTIVE + FP);
    localparam logic [9:0]  AT_BACK  = 10'(ACTIVE + FP + SYNC);

    vga_timing_pkg::phase_t state;
    logic [9:0]             count_next;

    assign wrap = advance && (count == LAST);

    always_comb begin
        count_next = count;
        state_next = state;
        if (advance) begin
            count_next = wrap ? '0 : count + 10'd1;
        end
        case (state)
            vga_timing_pkg::ACTIVE: if (advance && count_next == AT_FRONT) state_next = vga_timing_pkg::FRONT;
            vga_timing_pkg::FRONT:  if (advance && count_next == AT_SYNC)  state_next = vga_timing_pkg::SYNC;
            vga_timing_pkg::SYNC:   if (advance && count_next == AT_BACK)  state_next = vga_timing_pkg::BACK;
            vga_timing_pkg::BACK:   if (advance && count_next == '0)       state_next = vga_timing_pkg::ACTIVE;
            default:                state_next = vga_timing_pkg::BACK;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= LAST;
            state <= vga_timing_pkg::BACK;
        end else begin
            count <= count_next;
            state <= state_next;
        end
    end

endmodule

// File: rtl/vga_timing_controller.sv
// VGA raster timing: pixel-enable divider driving horizontal and vertical phase sequencers.
module vga_timing_controller
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          SYNC_POL = DEF_SYNC_POL
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic       pix_en,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       hs,
    output logic       vs,
    output logic       video_on,
    output logic       line_end,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
        $error("vga_timing_controller: H_TOTAL/V_TOTAL must not exceed 1024");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("vga_timing_controller: CLK_DIV must be in 1..16");
    end

    logic [3:0] divider;
    logic       div_wrap;
    logic       h_wrap;
    logic       v_wrap;
    phase_t     h_state_next;
    phase_t     v_state_next;

    assign div_wrap = enable && (divider == DIV_LAST);

    vga_axis_fsm #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk        (clk),
        .reset      (reset),
        .advance    (div_wrap),
        .count      (h_count),
        .wrap       (h_wrap),
        .state_next (h_state_next)
    );

    vga_axis_fsm #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk        (clk),
        .reset      (reset),
        .advance    (h_wrap),
        .count      (v_count),
        .wrap       (v_wrap),
        .state_next (v_state_next)
    );

    // Syncs and video_on decode the axes' next phase so they land on the same edge as the counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divider     <= '0;
            pix_en      <= 1'b0;
            line_end    <= 1'b0;
            frame_start <= 1'b0;
            hs          <= ~SYNC_POL;
            vs          <= ~SYNC_POL;
            video_on    <= 1'b0;
        end else if (enable) begin
            divider     <= div_wrap ? '0 : divider + 4'd1;
            pix_en      <= div_wrap;
            line_end    <= h_wrap;
            frame_start <= v_wrap;
            hs          <= (h_state_next == SYNC) ? SYNC_POL : ~SYNC_POL;
            vs          <= (v_state_next == SYNC) ? SYNC_POL : ~SYNC_POL;
            video_on    <= (h_state_next == ACTIVE) && (v_state_next == ACTIVE);
        end else begin
            pix_en      <= 1'b0;
            line_end    <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed self-checking bench: default 640x480 timing plus two reduced-geometry instances.
module tb_vga_timing_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Instance A: default timing, CLK_DIV=4
    logic       reset_a, en_a;
    logic       pix_en_a, hs_a, vs_a, von_a, le_a, fs_a;
    logic [9:0] h_a, v_a;

    vga_timing_controller #(.CLK_DIV(4)) dut_a (
        .clk(clk), .reset(reset_a), .enable(en_a), .pix_en(pix_en_a),
        .h_count(h_a), .v_count(v_a), .hs(hs_a), .vs(vs_a),
        .video_on(von_a), .line_end(le_a), .frame_start(fs_a)
    );

    // Instance B: 8x6 raster, every clk a pixel, active-high syncs
    logic       reset_b, en_b;
    logic       pix_en_b, hs_b, vs_b, von_b, le_b, fs_b;
    logic [9:0] h_b, v_b;

    vga_timing_controller #(
        .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
    ) dut_b (
        .clk(clk), .reset(reset_b), .enable(en_b), .pix_en(pix_en_b),
        .h_count(h_b), .v_count(v_b), .hs(hs_b), .vs(vs_b),
        .video_on(von_b), .line_end(le_b), .frame_start(fs_b)
    );

    // Instance C: 8-pixel lines, default 525-line vertical timing
    logic       reset_c, en_c;
    logic       pix_en_c, hs_c, vs_c, von_c, le_c, fs_c;
    logic [9:0] h_c, v_c;

    vga_timing_controller #(
        .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1)
    ) dut_c (
        .clk(clk), .reset(reset_c), .enable(en_c), .pix_en(pix_en_c),
        .h_count(h_c), .v_count(v_c), .hs(hs_c), .vs(vs_c),
        .video_on(von_c), .line_end(le_c), .frame_start(fs_c)
    );

    initial begin
        int cnt, cnt2, bad, bad2, le_cnt, found, first_fs, gap, vmax;
        int exp_h, exp_v;
        logic hs0, vs0, von0;
        logic [9:0] h0, v0;

        reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
        en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
        repeat (3) tick();

        check("a_rst_h", h_a, 799);
        check("a_rst_v", v_a, 524);
        check("a_rst_hs", hs_a, 1);
        check("a_rst_vs", vs_a, 1);
        check("a_rst_von", von_a, 0);
        check("a_rst_strobes", {pix_en_a, le_a, fs_a}, 0);

        // First pixel on the 4th edge after release
        reset_a = 1'b0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            cnt += pix_en_a;
        end
        check("a_pre_pix_en", cnt, 0);
        check("a_pre_h", h_a, 799);
        tick();
        check("a_first_pix_en", pix_en_a, 1);
        check("a_first_h", h_a, 0);
        check("a_first_v", v_a, 0);
        check("a_first_von", von_a, 1);
        check("a_first_fs", fs_a, 1);
        check("a_first_le", le_a, 1);

        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            cnt += pix_en_a;
        end
        tick();
        check("a_period_gap", cnt, 0);
        check("a_period_pix_en", pix_en_a, 1);
        check("a_second_h", h_a, 1);
        check("a_second_strobes", {le_a, fs_a}, 0);

        // One full line (3200 clks) sampled every clk
        cnt = 0; cnt2 = 0; bad = 0; bad2 = 0; le_cnt = 0;
        for (int i = 0; i < 3200; i++) begin
            tick();
            if (hs_a !== ((h_a >= 656 && h_a <= 751) ? 1'b0 : 1'b1)) bad++;
            if (hs_a === 1'b0) cnt++;
            if (von_a !== ((h_a < 640 && v_a < 480) ? 1'b1 : 1'b0)) bad2++;
            if (le_a === 1'b1) begin
                le_cnt++;
                if (h_a != 0) bad2++;
            end
            cnt2 += pix_en_a;
        end
        check("a_line_hs_low_clks", cnt, 384);
        check("a_line_hs_decode_bad", bad, 0);
        check("a_line_von_bad", bad2, 0);
        check("a_line_le_count", le_cnt, 1);
        check("a_line_pix_count", cnt2, 800);
        check("a_line_end_h", h_a, 1);
        check("a_line_end_v", v_a, 1);

        // Freeze mid-pixel at h_count=100
        found = 0;
        for (int i = 0; i < 1000 && found == 0; i++) begin
            tick();
            if (h_a == 100 && pix_en_a === 1'b1) found = 1;
        end
        check("a_wait_h100", found, 1);
        tick();
        en_a = 1'b0;
        hs0 = hs_a; vs0 = vs_a; von0 = von_a; h0 = h_a; v0 = v_a;
        cnt = 0; bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            cnt += pix_en_a + le_a + fs_a;
            if (h_a !== h0 || v_a !== v0 || hs_a !== hs0 || vs_a !== vs0 || von_a !== von0) bad++;
        end
        check("a_hold_strobes", cnt, 0);
        check("a_hold_changed", bad, 0);
        check("a_hold_h", h_a, 100);
        en_a = 1'b1;
        cnt = 0;
        tick(); cnt += pix_en_a;
        tick(); cnt += pix_en_a;
        check("a_resume_gap", cnt, 0);
        check("a_resume_h_before", h_a, 100);
        tick();
        check("a_resume_pix_en", pix_en_a, 1);
        check("a_resume_h", h_a, 101);

        // Asynchronous reset between edges while inside horizontal sync
        found = 0;
        for (int i = 0; i < 3000 && found == 0; i++) begin
            tick();
            if (h_a == 700) found = 1;
        end
        check("a_wait_h700", found, 1);
        check("a_h700_hs", hs_a, 0);
        #2;
        reset_a = 1'b1;
        #1;
        check("a_async_h", h_a, 799);
        check("a_async_v", v_a, 524);
        check("a_async_syncs", {hs_a, vs_a}, 3);
        check("a_async_von", von_a, 0);
        check("a_async_pix_en", pix_en_a, 0);
        tick();
        reset_a = 1'b0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            cnt += pix_en_a;
        end
        tick();
        check("a_restart_gap", cnt, 0);
        check("a_restart_fs", fs_a, 1);
        check("a_restart_pos", {h_a, v_a}, 0);

        // Instance B: tiny raster, SYNC_POL=1, CLK_DIV=1
        check("b_rst_h", h_b, 7);
        check("b_rst_v", v_b, 5);
        check("b_rst_syncs", {hs_b, vs_b}, 0);
        reset_b = 1'b0;
        exp_h = 7; exp_v = 5;
        bad = 0; cnt = 0; cnt2 = 0; le_cnt = 0; first_fs = -1; gap = -1;
        for (int i = 0; i < 96; i++) begin
            tick();
            exp_h = (exp_h + 1) % 8;
            if (exp_h == 0) exp_v = (exp_v + 1) % 6;
            if (h_b != exp_h || v_b != exp_v) bad++;
            if (hs_b !== ((exp_h >= 5 && exp_h <= 6) ? 1'b1 : 1'b0)) bad++;
            if (vs_b !== ((exp_v == 4) ? 1'b1 : 1'b0)) bad++;
            if (von_b !== ((exp_h < 4 && exp_v < 3) ? 1'b1 : 1'b0)) bad++;
            if (le_b !== ((exp_h == 0) ? 1'b1 : 1'b0)) bad++;
            if (pix_en_b !== 1'b1) bad++;
            cnt += hs_b;
            cnt2 += vs_b;
            if (fs_b === 1'b1) begin
                le_cnt++;
                if (first_fs < 0) first_fs = i;
                else gap = i - first_fs;
            end
        end
        check("b_sequence_bad", bad, 0);
        check("b_hs_high_clks", cnt, 24);
        check("b_vs_high_clks", cnt2, 16);
        check("b_fs_count", le_cnt, 2);
        check("b_fs_first", first_fs, 0);
        check("b_fs_gap", gap, 48);

        // Instance C: full 525-line vertical timing on short lines
        check("c_rst_vs", vs_c, 1);
        reset_c = 1'b0;
        bad = 0; cnt = 0; le_cnt = 0; first_fs = -1; gap = -1; vmax = 0;
        for (int i = 0; i < 8400; i++) begin
            tick();
            if (vs_c !== ((v_c >= 490 && v_c <= 491) ? 1'b0 : 1'b1)) bad++;
            if (vs_c === 1'b0) cnt++;
            if (int'(v_c) > vmax) vmax = int'(v_c);
            if (fs_c === 1'b1) begin
                le_cnt++;
                if (first_fs < 0) first_fs = i;
                else gap = i - first_fs;
            end
        end
        check("c_vs_decode_bad", bad, 0);
        check("c_vs_low_clks", cnt, 32);
        check("c_v_max", vmax, 524);
        check("c_fs_count", le_cnt, 2);
        check("c_fs_gap", gap, 4200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_controller.md
Name: vga_timing_controller

Overview:
- Generates VGA raster timing for the Pong display.
- Divides the system clock down to a pixel-enable strobe.
- Steps the horizontal and vertical position counters through the active, front porch, sync and back porch phases.
- Produces registered hs, vs, video_on, pixel coordinates and line/frame strobes for the pixel generator and game logic.
- Replaces free-running counter-plus-comparator sync generation with a single sequenced controller.

Parameters:
- CLK_DIV, 4: system clocks per pixel; 1..16. 100 MHz in gives a 25 MHz pixel rate.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- SYNC_POL, 0: asserted level of hs/vs; 0 means active-low.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  when low, freezes the divider, counters and all outputs.
- pix_en  out  1  one-clk strobe, once per pixel period.
- h_count  out  10  current pixel column, 0..H_TOTAL-1.
- v_count  out  10  current line, 0..V_TOTAL-1.
- hs  out  1  horizontal sync.
- vs  out  1  vertical sync.
- video_on  out  1  high when h_count < H_ACTIVE and v_count < V_ACTIVE.
- line_end  out  1  one-clk pulse coinciding with the pix_en that wraps h_count to 0.
- frame_start  out  1  one-clk pulse coinciding with the pix_en that moves to (0,0).

Behaviour:
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤1024; elaboration error otherwise.
- Reset (async, immediate):
  - divider = 0, h_count = H_TOTAL-1, v_count = V_TOTAL-1.
  - h_state = BACK, v_state = BACK.
  - hs = vs = !SYNC_POL (inactive); video_on = 0; pix_en = line_end = frame_start = 0.
  - Position is the last pixel of the frame, so the first advance lands on (0,0).
- Divider: while enable=1, counts 0..CLK_DIV-1 and wraps.
  - pix_en is registered and high for one clk on the cycle after divider = CLK_DIV-1.
  - After reset release, the first pix_en appears on the CLK_DIV-th rising edge with enable high.
- Horizontal FSM: ACTIVE→FRONT→SYNC→BACK→ACTIVE, advanced only on the edge where the divider wraps (same edge pix_en is set).
  - h_count increments; at H_TOTAL-1 it wraps to 0.
  - State transitions occur at h_count boundaries H_ACTIVE, H_ACTIVE+H_FP and H_ACTIVE+H_FP+H_SYNC, and at the wrap to 0.
- Vertical FSM: same four states, advanced only when the horizontal FSM wraps.
  - v_count increments; at V_TOTAL-1 it wraps to 0.
- Output timing:
  - hs, vs and video_on are registered and decoded from the next state/count, so they change on the same edge as h_count/v_count. No pipeline skew between coordinates and syncs.
  - hs asserted iff h_state = SYNC (h_count 656..751 with defaults).
  - vs asserted iff v_state = SYNC (v_count 490..491).
- Strobes:
  - line_end is set on the same edge as h_count 799→0.
  - frame_start is set on the same edge as (799,524)→(0,0); line_end is also high on that edge.
- enable=0:
  - The divider holds, and pix_en/line_end/frame_start are forced 0 on the next edge.
  - Counters, states, hs, vs and video_on hold.
  - When enable returns high, counting resumes from the held divider value with no skipped or duplicated pixel.
- Reset mid-frame: outputs return to reset values immediately. Counting restarts as from power-up, with the first pix_en after CLK_DIV enabled clocks.
- CLK_DIV = 1: pix_en is continuously high while enabled; every clk is a pixel.
- Counters never exceed TOTAL-1; no illegal FSM state is reachable. The default branch returns the FSM to BACK.

Decomposition:
- Package vga_timing_pkg:
  - default 640x480@60 timing constants;
  - H_TOTAL/V_TOTAL functions;
  - phase enum {ACTIVE, FRONT, SYNC, BACK} (2 bits);
  - sync polarity constant.
- Sub-module vga_axis_fsm, instantiated twice (horizontal, vertical):
  - parameters ACTIVE/FP/SYNC/BP;
  - inputs clk, reset, advance;
  - outputs count[9:0], state, wrap (combinational, high when advance is set and count = TOTAL-1).
  - Horizontal: advance = divider wrap. Vertical: advance = horizontal wrap.

Test Plan:
- Reset held 3 clks then released, CLK_DIV=4, enable=1 → first pix_en on the 4th edge; h_count=0, v_count=0, video_on=1, frame_start=1, line_end=1 in that cycle; pix_en period thereafter exactly 4 clks.
- Default params, run one line → hs asserted (0) exactly for h_count 656..751 (384 clks); video_on low from h_count 640; line_end once per 3200 clks.
- Full frame → vs asserted only for v_count 490..491; frame_start once per 800*525*4 = 1,680,000 clks; v_count never exceeds 524.
- Small params H=4/1/2/1, V=3/1/1/1, CLK_DIV=1 → h_count cycles 0..7, hs high-asserted at 5..6 when SYNC_POL=1, v_count wraps 0..5, frame_start every 48 clks.
- enable low for 10 clks at h_count=100 mid-pixel → counters, hs, vs, video_on held; no strobes; after re-enable the next pix_en arrives after the remaining divider cycles and h_count=101.
- reset asserted asynchronously at (700,300) between edges → immediately h_count=799, v_count=524, hs=vs=1, video_on=0; after release the frame restarts at (0,0) with frame_start.
